// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the board reset/bring-up sequencer.
package reset_sequencer_pkg;

  // Encodings are visible on io_state (debug LEDs), so keep them fixed.
  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_DRAM_RESET = 3'd2,
    ST_WAIT_CALIB = 3'd3,
    ST_CORE_DELAY = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  // Width of the shared phase counter: enough to hold the largest terminal
  // count (largest cycle parameter minus one), never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-side signals of the reset sequencer: lock/calibration status in,
// DRAM/core resets and debug status out.
interface reset_sequencer_if #(
  parameter int N_LOCK = 3
);
  logic [N_LOCK-1:0] io_locked;
  logic              io_calib_complete;
  logic              io_dram_sys_reset;
  logic              io_dram_aresetn;
  logic              io_core_reset;
  logic [2:0]        io_state;
  logic              io_fault;
  logic [1:0]        io_retries;

  // Board/wrapper side: supplies status, consumes resets.
  modport master (
    output io_locked, io_calib_complete,
    input  io_dram_sys_reset, io_dram_aresetn, io_core_reset,
    input  io_state, io_fault, io_retries
  );

  // Sequencer side.
  modport slave (
    input  io_locked, io_calib_complete,
    output io_dram_sys_reset, io_dram_aresetn, io_core_reset,
    output io_state, io_fault, io_retries
  );
endinterface

// File: rtl/reset_sequencer_sync.sv
// Two-flop synchronizer for asynchronous status inputs; clears to 0 so that
// nothing looks locked or calibrated while the sequencer is held in reset.
module reset_sequencer_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;
endmodule

// File: rtl/reset_sequencer.sv
// Board reset sequencer: waits for stable MMCM locks, releases the DRAM
// controller, waits for calibration (with timeout and bounded retries), then
// releases the core. Lock loss or calibration loss re-sequences.
//
// state       | meaning
// RESET       | one cycle after reset release
// WAIT_LOCK   | waiting for all locks to be stable for LOCK_STABLE_CYCLES
// DRAM_RESET  | DRAM held in reset for DRAM_HOLD_CYCLES
// WAIT_CALIB  | DRAM released, waiting for init_calib_complete
// CORE_DELAY  | calibrated, core held for CORE_DELAY_CYCLES
// RUN         | everything released
// FAULT       | retries exhausted, all resets held until board reset
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_LOCK               = 3,
  parameter int LOCK_STABLE_CYCLES   = 1024,
  parameter int DRAM_HOLD_CYCLES     = 16,
  parameter int CALIB_TIMEOUT_CYCLES = 16777216,
  parameter int CORE_DELAY_CYCLES    = 16,
  parameter int MAX_RETRIES          = 3
) (
  input logic              clock,
  input logic              reset,
  reset_sequencer_if.slave bus
);
  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, DRAM_HOLD_CYCLES,
                                CALIB_TIMEOUT_CYCLES, CORE_DELAY_CYCLES);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(DRAM_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CORE_LAST  = CW'(CORE_DELAY_CYCLES - 1);

  logic [N_LOCK:0] sync_s;
  logic            all_locked;
  logic            calib_s;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      retries_q, retries_d;
  logic [1:0]      retry_inc;
  logic            sys_reset_q, sys_reset_d;
  logic            aresetn_q, aresetn_d;
  logic            core_reset_q, core_reset_d;
  logic            fault_q, fault_d;

  reset_sequencer_sync #(.WIDTH(N_LOCK + 1)) u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i ({bus.io_calib_complete, bus.io_locked}),
    .sync_o  (sync_s)
  );

  assign all_locked = &sync_s[N_LOCK-1:0];
  assign calib_s    = sync_s[N_LOCK];
  assign retry_inc  = (retries_q == 2'b11) ? 2'b11 : retries_q + 2'b01;

  // Next state, shared counter and retry count; outputs decoded from state_d
  // so they register in the same cycle as the state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    retries_d    = retries_q;
    sys_reset_d  = 1'b1;
    aresetn_d    = 1'b0;
    core_reset_d = 1'b1;

    case (state_q)
      ST_RESET: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (!all_locked)              cnt_d   = '0;
        else if (cnt_q == LOCK_LAST)  state_d = ST_DRAM_RESET;
      end
      ST_DRAM_RESET: begin
        if (!all_locked)              state_d = ST_WAIT_LOCK;
        else if (cnt_q == HOLD_LAST)  state_d = ST_WAIT_CALIB;
      end
      ST_WAIT_CALIB: begin
        if (!all_locked) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == CALIB_LAST) begin
          retries_d = retry_inc;
          state_d   = (int'(retry_inc) < MAX_RETRIES) ? ST_DRAM_RESET : ST_FAULT;
        end else if (calib_s) begin
          state_d = ST_CORE_DELAY;
        end
      end
      ST_CORE_DELAY: begin
        if (!all_locked)              state_d = ST_WAIT_LOCK;
        else if (!calib_s)            state_d = ST_DRAM_RESET;
        else if (cnt_q == CORE_LAST)  state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!all_locked)              state_d = ST_WAIT_LOCK;
        else if (!calib_s)            state_d = ST_DRAM_RESET;
      end
      ST_FAULT: cnt_d = cnt_q;
      default:  state_d = ST_RESET;
    endcase

    if (state_d != state_q) cnt_d = '0;

    case (state_d)
      ST_WAIT_CALIB, ST_CORE_DELAY: begin
        sys_reset_d = 1'b0;
        aresetn_d   = 1'b1;
      end
      ST_RUN: begin
        sys_reset_d  = 1'b0;
        aresetn_d    = 1'b1;
        core_reset_d = 1'b0;
      end
      default: ;
    endcase
    fault_d = (state_d == ST_FAULT);
  end

  // State, counter and registered reset outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET;
      cnt_q        <= '0;
      retries_q    <= '0;
      sys_reset_q  <= 1'b1;
      aresetn_q    <= 1'b0;
      core_reset_q <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retries_q    <= retries_d;
      sys_reset_q  <= sys_reset_d;
      aresetn_q    <= aresetn_d;
      core_reset_q <= core_reset_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.io_state          = state_q;
  assign bus.io_dram_sys_reset = sys_reset_q;
  assign bus.io_dram_aresetn   = aresetn_q;
  assign bus.io_core_reset     = core_reset_q;
  assign bus.io_fault          = fault_q;
  assign bus.io_retries        = retries_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with shortened cycle parameters.
module tb_reset_sequencer;
  localparam int LSC  = 8;
  localparam int HOLD = 4;
  localparam int TO   = 32;
  localparam int CD   = 4;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] locked_drv = 3'b000;
  logic       calib_drv  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  // Reference model: phase number, cycles spent in phase, consecutive locked
  // cycles, retry count, and a two-deep delay line for input latency.
  int         m_phase, m_age, m_stable, m_ret;
  logic [3:0] hist[$];

  always #5 clk = ~clk;

  reset_sequencer_if #(.N_LOCK(3)) bus ();
  assign bus.io_locked         = locked_drv;
  assign bus.io_calib_complete = calib_drv;

  reset_sequencer #(
    .N_LOCK(3), .LOCK_STABLE_CYCLES(LSC), .DRAM_HOLD_CYCLES(HOLD),
    .CALIB_TIMEOUT_CYCLES(TO), .CORE_DELAY_CYCLES(CD), .MAX_RETRIES(MAXR)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_age = 0; m_stable = 0; m_ret = 0;
        hist.delete();
        hist.push_back(4'b0);
        hist.push_back(4'b0);
      end else begin
        logic [3:0] u;
        logic       lk, cal;
        int         nxt;
        u = hist.pop_front();
        hist.push_back({calib_drv, locked_drv});
        lk  = &u[2:0];
        cal = u[3];
        nxt = m_phase;
        case (m_phase)
          0: nxt = 1;
          1: begin
            m_stable = lk ? m_stable + 1 : 0;
            if (m_stable == LSC) nxt = 2;
          end
          2: begin
            m_age++;
            if (!lk) nxt = 1;
            else if (m_age == HOLD) nxt = 3;
          end
          3: begin
            m_age++;
            if (!lk) nxt = 1;
            else if (m_age == TO) begin
              m_ret = (m_ret < 3) ? m_ret + 1 : 3;
              nxt = (m_ret < MAXR) ? 2 : 6;
            end else if (cal) nxt = 4;
          end
          4: begin
            m_age++;
            if (!lk) nxt = 1;
            else if (!cal) nxt = 2;
            else if (m_age == CD) nxt = 5;
          end
          5: begin
            if (!lk) nxt = 1;
            else if (!cal) nxt = 2;
          end
          default: ;
        endcase
        if (nxt != m_phase) begin
          m_age = 0;
          m_stable = 0;
        end
        m_phase = nxt;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        logic [9:0] got, exp;
        logic [2:0] rs;
        case (m_phase)
          3, 4:    rs = 3'b011;
          5:       rs = 3'b010;
          default: rs = 3'b101;
        endcase
        exp = {3'(m_phase), rs, (m_phase == 6), 2'(m_ret)};
        got = {bus.io_state, bus.io_dram_sys_reset, bus.io_dram_aresetn,
               bus.io_core_reset, bus.io_fault, bus.io_retries};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL lockstep t=%0t state|sys|aresetn|core|fault|retries got %b want %b",
                   $time, got, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [2:0] lk, input logic cal);
    @(negedge clk);
    rst = 1'b1;
    locked_drv = lk;
    calib_drv  = cal;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (bus.io_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.io_state !== s) begin
      miscompares++;
      $display("FAIL %s: state %0d after %0d cycles, wanted %0d", tag, bus.io_state, n, s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    vectors += 4;
    if (bus.io_state !== 3'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d want 0", bus.io_state);
    end
    if ({bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset} !== 3'b101) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 101",
               {bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset});
    end
    if (bus.io_fault !== 1'b0) begin
      miscompares++; $display("FAIL reset_fault: got %b want 0", bus.io_fault);
    end
    if (bus.io_retries !== 2'd0) begin
      miscompares++; $display("FAIL reset_retries: got %0d want 0", bus.io_retries);
    end
  endtask

  task automatic test_nominal();
    logic [2:0] seq[$];
    logic [2:0] last;
    int n = 0, t2 = -1, tfall = -1, t4 = -1, tcore = -1;
    do_reset(3'b111, 1'b0);
    seq.push_back(bus.io_state);
    last = bus.io_state;
    while (bus.io_state !== 3'd5 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.io_state !== last) seq.push_back(bus.io_state);
      last = bus.io_state;
      if (bus.io_state === 3'd2 && t2 < 0) t2 = n;
      if (t2 >= 0 && tfall < 0 && bus.io_dram_sys_reset === 1'b0) tfall = n;
      if (tfall >= 0 && n == tfall + 5) calib_drv = 1'b1;
      if (bus.io_state === 3'd4 && t4 < 0) t4 = n;
      if (t4 >= 0 && tcore < 0 && bus.io_core_reset === 1'b0) tcore = n;
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (seq.size() <= i || seq[i] !== 3'(i)) begin
        miscompares++;
        $display("FAIL nominal_seq[%0d]: got %0d want %0d", i,
                 (seq.size() > i) ? seq[i] : 3'd7, i);
      end
    end
    vectors += 3;
    if (tfall - t2 !== HOLD) begin
      miscompares++; $display("FAIL nominal_sys_fall: got %0d cycles want %0d", tfall - t2, HOLD);
    end
    if (tcore - t4 !== CD) begin
      miscompares++; $display("FAIL nominal_core_fall: got %0d cycles want %0d", tcore - t4, CD);
    end
    if (bus.io_retries !== 2'd0) begin
      miscompares++; $display("FAIL nominal_retries: got %0d want 0", bus.io_retries);
    end
  endtask

  task automatic test_lock_glitch();
    int n = 0;
    do_reset(3'b111, 1'b0);
    while (m_stable != 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (m_stable != 5 || bus.io_state !== 3'd1) begin
      miscompares++; $display("FAIL glitch_setup: state %0d, want 1 with count 5", bus.io_state);
    end
    locked_drv = 3'b101;
    @(negedge clk);
    locked_drv = 3'b111;
    n = 0;
    while (bus.io_state !== 3'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== LSC + 2) begin
      miscompares++; $display("FAIL glitch_restart: state 2 after %0d cycles want %0d", n, LSC + 2);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset(3'b111, 1'b0);
    wait_state(3'd3, 60, "timeout_enter");
    while (bus.io_state === 3'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors += 3;
    if (n !== TO) begin
      miscompares++; $display("FAIL timeout_len: %0d cycles in state 3 want %0d", n, TO);
    end
    if (bus.io_state !== 3'd2) begin
      miscompares++; $display("FAIL timeout_retry_state: got %0d want 2", bus.io_state);
    end
    if (bus.io_retries !== 2'd1) begin
      miscompares++; $display("FAIL timeout_retries1: got %0d want 1", bus.io_retries);
    end
    wait_state(3'd3, 20, "timeout_reenter");
    wait_state(3'd6, 60, "timeout_fault");
    vectors += 3;
    if (bus.io_retries !== 2'd2) begin
      miscompares++; $display("FAIL timeout_retries2: got %0d want 2", bus.io_retries);
    end
    if (bus.io_fault !== 1'b1) begin
      miscompares++; $display("FAIL timeout_fault_flag: got %b want 1", bus.io_fault);
    end
    if ({bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset} !== 3'b101) begin
      miscompares++;
      $display("FAIL timeout_fault_resets: got %b want 101",
               {bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset});
    end
    repeat (20) begin
      locked_drv = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    locked_drv = 3'b111;
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.io_state !== 3'd6 || bus.io_fault !== 1'b1) begin
      miscompares++; $display("FAIL fault_sticky: state %0d fault %b want 6/1", bus.io_state, bus.io_fault);
    end
  endtask

  task automatic test_lock_loss_run();
    int n = 0;
    do_reset(3'b111, 1'b0);
    wait_state(3'd3, 60, "lockloss_calib");
    repeat ($urandom_range(0, 10)) @(negedge clk);
    calib_drv = 1'b1;
    wait_state(3'd5, 60, "lockloss_run");
    repeat ($urandom_range(0, 5)) @(negedge clk);
    locked_drv = 3'b110;
    while (bus.io_state !== 3'd1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors += 3;
    if (n !== 3) begin
      miscompares++; $display("FAIL lockloss_latency: %0d cycles want 3", n);
    end
    if ({bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset} !== 3'b101) begin
      miscompares++;
      $display("FAIL lockloss_resets: got %b want 101",
               {bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset});
    end
    if (bus.io_retries !== 2'd0) begin
      miscompares++; $display("FAIL lockloss_retries: got %0d want 0", bus.io_retries);
    end
    locked_drv = 3'b111;
    wait_state(3'd5, 80, "lockloss_resequence");
    vectors++;
    if (bus.io_retries !== 2'd0) begin
      miscompares++; $display("FAIL lockloss_retries_after: got %0d want 0", bus.io_retries);
    end
  endtask

  task automatic test_timeout_lockloss();
    do_reset(3'b111, 1'b0);
    wait_state(3'd3, 60, "coincide_enter");
    wait_state(3'd2, 40, "coincide_first_timeout");
    wait_state(3'd3, 20, "coincide_reenter");
    repeat (TO - 3) @(negedge clk);
    vectors++;
    if (bus.io_state !== 3'd3) begin
      miscompares++; $display("FAIL coincide_setup: got %0d want 3", bus.io_state);
    end
    locked_drv = 3'b011;
    repeat (3) @(negedge clk);
    vectors += 3;
    if (bus.io_state !== 3'd1) begin
      miscompares++; $display("FAIL coincide_state: got %0d want 1", bus.io_state);
    end
    if (bus.io_retries !== 2'd1) begin
      miscompares++; $display("FAIL coincide_retries: got %0d want 1", bus.io_retries);
    end
    if (bus.io_fault !== 1'b0) begin
      miscompares++; $display("FAIL coincide_fault: got %b want 0", bus.io_fault);
    end
    locked_drv = 3'b111;
  endtask

  task automatic test_async_reset();
    do_reset(3'b111, 1'b0);
    wait_state(3'd3, 60, "async_enter");
    wait_state(3'd2, 40, "async_timeout");
    wait_state(3'd3, 20, "async_reenter");
    calib_drv = 1'b1;
    wait_state(3'd4, 10, "async_core_delay");
    #3;
    rst = 1'b1;
    #1;
    vectors += 4;
    if (bus.io_state !== 3'd0) begin
      miscompares++; $display("FAIL async_state: got %0d want 0", bus.io_state);
    end
    if ({bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset} !== 3'b101) begin
      miscompares++;
      $display("FAIL async_resets: got %b want 101",
               {bus.io_dram_sys_reset, bus.io_dram_aresetn, bus.io_core_reset});
    end
    if (bus.io_retries !== 2'd0) begin
      miscompares++; $display("FAIL async_retries: got %0d want 0", bus.io_retries);
    end
    if (bus.io_fault !== 1'b0) begin
      miscompares++; $display("FAIL async_fault: got %b want 0", bus.io_fault);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int round = 0; round < 3; round++) begin
      do_reset(3'b111, 1'b0);
      repeat (400) begin
        @(negedge clk);
        if (locked_drv != 3'b111 && $urandom_range(0, 3) == 0)
          locked_drv = 3'b111;
        else if ($urandom_range(0, 60) == 0)
          locked_drv[$urandom_range(0, 2)] = 1'b0;
        if ($urandom_range(0, 40) == 0)
          calib_drv = ~calib_drv;
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_timeout();
    test_lock_loss_run();
    test_timeout_lockloss();
    test_async_reset();
    test_random();
    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
